// File: rtl/rt_block_commit_pkg.sv
// Shared constants for the block-write commit path: FSM encoding and data-word layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rt_block_commit_pkg;

    // Collect FSM encoding
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    // Staged data word layout
    localparam int DAC_VALID_BIT = 31;
    localparam int AMP_MASK_BIT  = 29;
    localparam int AMP_VAL_BIT   = 28;

    // Register-map offset of the per-channel DAC/amp control word (shared map constant)
    localparam logic [3:0] OFF_DAC_CTRL = 4'h0;

    // Full address that, with both strobes high, carries a power-control quadlet
    localparam logic [7:0] ADDR_QUADLET = 8'h00;

endpackage

// File: rtl/rt_dac_drain.sv
// Drains committed DAC setpoints one channel at a time, lowest pending index first.
// Latency: dac_req rises the cycle after a commit; one idle cycle between requests.
// Backpressure: dac_chan/dac_data held until dac_ack; later commits only update pending state.
module rt_dac_drain #(
    parameter int NUM_MOTORS = 4,
    parameter int CW         = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MOTORS-1:0]       upd_mask,
    input  logic [NUM_MOTORS-1:0][15:0] upd_data,
    input  logic                        dac_ack,
    output logic                        dac_req,
    output logic [2:0]                  dac_chan,
    output logic [15:0]                 dac_data,
    output logic                        pending_any
);

    logic [NUM_MOTORS-1:0]       pending;
    logic [NUM_MOTORS-1:0]       merged;
    logic [NUM_MOTORS-1:0]       cur_onehot;
    logic [NUM_MOTORS-1:0]       ack_clr;
    logic [NUM_MOTORS-1:0][15:0] dac_buf;
    logic [CW-1:0]               cur;
    logic [CW-1:0]               sel_idx;
    logic                        sel_vld;
    logic                        stale;
    logic                        keep_cur;

    // Lowest-index pending channel, counting a commit landing this cycle
    always_comb begin
        merged  = pending | upd_mask;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
            if (merged[i]) begin
                sel_vld = 1'b1;
                sel_idx = CW'(i);
            end
        end
    end

    // Pending bit of the channel in flight is kept if a newer value arrived during the transfer
    always_comb begin
        cur_onehot      = '0;
        cur_onehot[cur] = 1'b1;
    end

    assign keep_cur = stale | upd_mask[cur];
    assign ack_clr  = cur_onehot & {NUM_MOTORS{~keep_cur}};

    // Pending bitmap, value buffer and req/ack handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            dac_buf <= '0;
            dac_req <= 1'b0;
            cur     <= '0;
            dac_data <= '0;
            stale   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (upd_mask[i]) begin
                    dac_buf[i] <= upd_data[i];
                end
            end
            if (dac_req) begin
                if (dac_ack) begin
                    dac_req <= 1'b0;
                    stale   <= 1'b0;
                    pending <= (pending & ~ack_clr) | upd_mask;
                end else begin
                    pending <= pending | upd_mask;
                    if (upd_mask[cur]) begin
                        stale <= 1'b1;
                    end
                end
            end else begin
                // dac_ack while idle is ignored
                pending <= pending | upd_mask;
                if (sel_vld) begin
                    dac_req  <= 1'b1;
                    cur      <= sel_idx;
                    dac_data <= upd_mask[sel_idx] ? upd_data[sel_idx] : dac_buf[sel_idx];
                end
            end
        end
    end

    assign dac_chan    = 3'(cur);
    assign pending_any = |pending;

endmodule

// File: rtl/rt_block_commit.sv
// Stages per-channel DAC/amp words during a block write and commits them atomically.
// Latency: amp/ctrl pulses and first dac_req one cycle after the commit/quadlet strobe.
// Backpressure: DAC drain waits on dac_ack; block writes are never stalled.
module rt_block_commit
    import rt_block_commit_pkg::*;
#(
    parameter int NUM_MOTORS  = 4,   // 4 or 8
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bw_write_en,
    input  logic                  bw_reg_wen,
    input  logic                  bw_block_wen,
    input  logic                  bw_block_wstart,
    input  logic [7:0]            bw_reg_waddr,
    input  logic [31:0]           bw_reg_wdata,
    output logic                  dac_req,
    output logic [2:0]            dac_chan,
    output logic [15:0]           dac_data,
    input  logic                  dac_ack,
    output logic                  amp_en_wen,
    output logic [NUM_MOTORS-1:0] amp_en_mask,
    output logic [NUM_MOTORS-1:0] amp_en_val,
    output logic                  ctrl_wen,
    output logic [31:0]           ctrl_wdata,
    input  logic                  err_clr,
    output logic                  commit_err,
    output logic                  busy
);

    localparam int         CW     = (NUM_MOTORS > 4) ? 3 : 2;
    localparam int         TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] MAX_CH = 4'(NUM_MOTORS);

    logic [0:0]                  st;
    logic [TW-1:0]               timer;
    logic [NUM_MOTORS-1:0]       stg_dac_vld;
    logic [NUM_MOTORS-1:0]       stg_amp_mask;
    logic [NUM_MOTORS-1:0]       stg_amp_val;
    logic [NUM_MOTORS-1:0][15:0] stg_dac;
    logic [3:0]                  wr_ch;
    logic [CW-1:0]               wr_slot;
    logic                        ch_ok;
    logic                        in_collect;
    logic                        start;
    logic                        stg_wr;
    logic                        commit;
    logic                        timeout;
    logic                        quadlet;
    logic [NUM_MOTORS-1:0]       upd_mask;
    logic                        drain_pending;
    logic                        bus_unused;

    // Strobes are only ever raised inside a bus write, so the bus-active qualifier adds nothing
    assign bus_unused = bw_write_en;

    assign wr_ch      = bw_reg_waddr[7:4];
    assign wr_slot    = CW'(wr_ch - 4'd1);
    assign ch_ok      = (wr_ch != 4'd0) && (wr_ch <= MAX_CH);
    assign in_collect = (st == ST_COLLECT);
    assign start      = (st == ST_IDLE) && bw_block_wstart;
    assign stg_wr     = in_collect && bw_reg_wen && !bw_block_wen
                        && (bw_reg_waddr[3:0] == OFF_DAC_CTRL) && ch_ok;
    assign commit     = in_collect && bw_block_wen && !bw_reg_wen;
    assign timeout    = in_collect && !commit && (timer == TW'(TIMEOUT_CYC - 1));
    assign quadlet    = bw_reg_wen && bw_block_wen && (bw_reg_waddr == ADDR_QUADLET);
    assign upd_mask   = commit ? stg_dac_vld : '0;

    // Collect FSM and its watchdog timer
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= ST_IDLE;
            timer <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (bw_block_wstart) begin
                        st    <= ST_COLLECT;
                        timer <= '0;
                    end
                end
                default: begin
                    if (commit || timeout) begin
                        st <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
            endcase
        end
    end

    // Staging registers: cleared at block start, commit and timeout; last write per channel wins
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_dac_vld  <= '0;
            stg_amp_mask <= '0;
            stg_amp_val  <= '0;
            stg_dac      <= '0;
        end else if (start || commit || timeout) begin
            stg_dac_vld  <= '0;
            stg_amp_mask <= '0;
            stg_amp_val  <= '0;
        end else if (stg_wr) begin
            stg_dac_vld[wr_slot]  <= bw_reg_wdata[DAC_VALID_BIT];
            stg_amp_mask[wr_slot] <= bw_reg_wdata[AMP_MASK_BIT];
            stg_amp_val[wr_slot]  <= bw_reg_wdata[AMP_VAL_BIT];
            stg_dac[wr_slot]      <= bw_reg_wdata[15:0];
        end
    end

    // Amp-enable update pulse, only when the committed block touched some amp
    always_ff @(posedge clk) begin
        if (reset) begin
            amp_en_wen  <= 1'b0;
            amp_en_mask <= '0;
            amp_en_val  <= '0;
        end else begin
            amp_en_wen <= commit && (|stg_amp_mask);
            if (commit && (|stg_amp_mask)) begin
                amp_en_mask <= stg_amp_mask;
                amp_en_val  <= stg_amp_val & stg_amp_mask;
            end
        end
    end

    // Power-control quadlet pass-through, independent of the collect FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_wen   <= 1'b0;
            ctrl_wdata <= '0;
        end else begin
            ctrl_wen <= quadlet;
            if (quadlet) begin
                ctrl_wdata <= bw_reg_wdata;
            end
        end
    end

    // Sticky timeout flag; a new timeout outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_err <= 1'b0;
        end else if (timeout) begin
            commit_err <= 1'b1;
        end else if (err_clr) begin
            commit_err <= 1'b0;
        end
    end

    rt_dac_drain #(
        .NUM_MOTORS (NUM_MOTORS),
        .CW         (CW)
    ) u_drain (
        .clk         (clk),
        .reset       (reset),
        .upd_mask    (upd_mask),
        .upd_data    (stg_dac),
        .dac_ack     (dac_ack),
        .dac_req     (dac_req),
        .dac_chan    (dac_chan),
        .dac_data    (dac_data),
        .pending_any (drain_pending)
    );

    assign busy = in_collect || drain_pending;

endmodule

// File: tb/tb_rt_block_commit.sv
// Directed table-driven bench for rt_block_commit (4 channels, 255-cycle timeout).
// Each vector drives one cycle of inputs and checks all outputs #1 after the clock edge.
module tb_rt_block_commit;

    typedef struct {
        string       name;
        logic        rst, ws, rw, bw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        ack, ec;
        logic        rq;
        logic [2:0]  ch;
        logic [15:0] dd;
        logic        aw;
        logic [3:0]  am, av;
        logic        cw;
        logic [31:0] cd;
        logic        er, bz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        bw_write_en, bw_reg_wen, bw_block_wen, bw_block_wstart;
    logic [7:0]  bw_reg_waddr;
    logic [31:0] bw_reg_wdata;
    logic        dac_req;
    logic [2:0]  dac_chan;
    logic [15:0] dac_data;
    logic        dac_ack;
    logic        amp_en_wen;
    logic [3:0]  amp_en_mask, amp_en_val;
    logic        ctrl_wen;
    logic [31:0] ctrl_wdata;
    logic        err_clr, commit_err, busy;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    rt_block_commit #(.NUM_MOTORS(4), .TIMEOUT_CYC(255)) dut (
        .clk             (clk),
        .reset           (reset),
        .bw_write_en     (bw_write_en),
        .bw_reg_wen      (bw_reg_wen),
        .bw_block_wen    (bw_block_wen),
        .bw_block_wstart (bw_block_wstart),
        .bw_reg_waddr    (bw_reg_waddr),
        .bw_reg_wdata    (bw_reg_wdata),
        .dac_req         (dac_req),
        .dac_chan        (dac_chan),
        .dac_data        (dac_data),
        .dac_ack         (dac_ack),
        .amp_en_wen      (amp_en_wen),
        .amp_en_mask     (amp_en_mask),
        .amp_en_val      (amp_en_val),
        .ctrl_wen        (ctrl_wen),
        .ctrl_wdata      (ctrl_wdata),
        .err_clr         (err_clr),
        .commit_err      (commit_err),
        .busy            (busy)
    );

    function automatic vec_t mk(string nm, logic rst, logic ws, logic rw, logic bw,
                                logic [7:0] ad, logic [31:0] wd, logic ack, logic ec,
                                logic rq, logic [2:0] ch, logic [15:0] dd, logic aw,
                                logic [3:0] am, logic [3:0] av, logic cw, logic [31:0] cd,
                                logic er, logic bz);
        vec_t v;
        v.name = nm; v.rst = rst; v.ws = ws; v.rw = rw; v.bw = bw;
        v.addr = ad; v.wdata = wd; v.ack = ack; v.ec = ec;
        v.rq = rq; v.ch = ch; v.dd = dd; v.aw = aw; v.am = am; v.av = av;
        v.cw = cw; v.cd = cd; v.er = er; v.bz = bz;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset           = v.rst;
        bw_block_wstart = v.ws;
        bw_reg_wen      = v.rw;
        bw_block_wen    = v.bw;
        bw_write_en     = v.ws | v.rw | v.bw;
        bw_reg_waddr    = v.addr;
        bw_reg_wdata    = v.wdata;
        dac_ack         = v.ack;
        err_clr         = v.ec;
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        n_vec++;
        if (dac_req !== v.rq || dac_chan !== v.ch || dac_data !== v.dd ||
            amp_en_wen !== v.aw || amp_en_mask !== v.am || amp_en_val !== v.av ||
            ctrl_wen !== v.cw || ctrl_wdata !== v.cd || commit_err !== v.er || busy !== v.bz) begin
            n_miss++;
            $display("FAIL %s: got req=%0b chan=%0d data=%h amp=%0b/%b/%b ctrl=%0b/%h err=%0b busy=%0b; want req=%0b chan=%0d data=%h amp=%0b/%b/%b ctrl=%0b/%h err=%0b busy=%0b",
                     v.name, dac_req, dac_chan, dac_data, amp_en_wen, amp_en_mask, amp_en_val,
                     ctrl_wen, ctrl_wdata, commit_err, busy,
                     v.rq, v.ch, v.dd, v.aw, v.am, v.av, v.cw, v.cd, v.er, v.bz);
        end
    endtask

    task automatic idle_cycles(input int n);
        drive(mk("idle", 0,0,0,0, 8'h00, 32'h0, 0,0, 0,0,16'h0,0,4'h0,4'h0,0,32'h0,0,0));
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        drive(mk("init", 1,0,0,0, 8'h00, 32'h0, 0,0, 0,0,16'h0,0,4'h0,4'h0,0,32'h0,0,0));

        // name, rst ws rw bw addr wdata ack ec | req chan data aw am av cw cd err busy
        tbl.push_back(mk("reset",        1,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,0,0));
        tbl.push_back(mk("quad_idle",    0,0,1,1, 8'h00, 32'h000F_0005, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,1,32'h000F_0005,0,0));
        tbl.push_back(mk("quad_end",     0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h000F_0005,0,0));
        tbl.push_back(mk("wstart",       0,1,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("wr_ch1",       0,0,1,0, 8'h10, 32'h8000_1234, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("wr_ch3",       0,0,1,0, 8'h30, 32'h8000_00AA, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("wr_ch0_ign",   0,0,1,0, 8'h00, 32'h8000_5555, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("wr_ch5_ign",   0,0,1,0, 8'h50, 32'h8000_6666, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("wr_off_ign",   0,0,1,0, 8'h21, 32'h8000_7777, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("commit1",      0,0,0,1, 8'h00, 32'h0000_0000, 0,0, 1,0,16'h1234,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("hold_ch0",     0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 1,0,16'h1234,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("ack_ch0",      0,0,0,0, 8'h00, 32'h0000_0000, 1,0, 0,0,16'h1234,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("req_ch2",      0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 1,2,16'h00AA,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("ack_ch2",      0,0,0,0, 8'h00, 32'h0000_0000, 1,0, 0,2,16'h00AA,0,4'b0000,4'b0000,0,32'h000F_0005,0,0));
        tbl.push_back(mk("ack_no_req",   0,0,0,0, 8'h00, 32'h0000_0000, 1,0, 0,2,16'h00AA,0,4'b0000,4'b0000,0,32'h000F_0005,0,0));
        tbl.push_back(mk("amp_wstart",   0,1,0,0, 8'h00, 32'h0000_0000, 0,0, 0,2,16'h00AA,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("amp_wr_ch2",   0,0,1,0, 8'h20, 32'h3000_0000, 0,0, 0,2,16'h00AA,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("amp_wr_ch4",   0,0,1,0, 8'h40, 32'h2000_0000, 0,0, 0,2,16'h00AA,0,4'b0000,4'b0000,0,32'h000F_0005,0,1));
        tbl.push_back(mk("amp_commit",   0,0,0,1, 8'h00, 32'h0000_0000, 0,0, 0,2,16'h00AA,1,4'b1010,4'b0010,0,32'h000F_0005,0,0));
        tbl.push_back(mk("amp_end",      0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,2,16'h00AA,0,4'b1010,4'b0010,0,32'h000F_0005,0,0));
        tbl.push_back(mk("q_wstart",     0,1,0,0, 8'h00, 32'h0000_0000, 0,0, 0,2,16'h00AA,0,4'b1010,4'b0010,0,32'h000F_0005,0,1));
        tbl.push_back(mk("q_wr_ch1",     0,0,1,0, 8'h10, 32'h8000_0ABC, 0,0, 0,2,16'h00AA,0,4'b1010,4'b0010,0,32'h000F_0005,0,1));
        tbl.push_back(mk("q_in_collect", 0,0,1,1, 8'h00, 32'hDEAD_BEEF, 0,0, 0,2,16'h00AA,0,4'b1010,4'b0010,1,32'hDEAD_BEEF,0,1));
        tbl.push_back(mk("q_commit",     0,0,0,1, 8'h00, 32'h0000_0000, 0,0, 1,0,16'h0ABC,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        tbl.push_back(mk("q_ack",        0,0,0,0, 8'h00, 32'h0000_0000, 1,0, 0,0,16'h0ABC,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,0));

        foreach (tbl[i]) apply(tbl[i]);

        // Overlap: ch0 ack withheld while a second block rewrites ch0
        apply(mk("ov_wstart",    0,1,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0ABC,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_wr_ch1",    0,0,1,0, 8'h10, 32'h8000_1234, 0,0, 0,0,16'h0ABC,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_wr_ch3",    0,0,1,0, 8'h30, 32'h8000_00AA, 0,0, 0,0,16'h0ABC,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_commit1",   0,0,0,1, 8'h00, 32'h0000_0000, 0,0, 1,0,16'h1234,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_wstart2",   0,1,0,0, 8'h00, 32'h0000_0000, 0,0, 1,0,16'h1234,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_wr_ch1_new",0,0,1,0, 8'h10, 32'h8000_0777, 0,0, 1,0,16'h1234,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_commit2",   0,0,0,1, 8'h00, 32'h0000_0000, 0,0, 1,0,16'h1234,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_ack_old",   0,0,0,0, 8'h00, 32'h0000_0000, 1,0, 0,0,16'h1234,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_rereq_ch0", 0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 1,0,16'h0777,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_ack_new",   0,0,0,0, 8'h00, 32'h0000_0000, 1,0, 0,0,16'h0777,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));
        apply(mk("ov_req_ch2",   0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 1,2,16'h00AA,0,4'b1010,4'b0010,0,32'hDEAD_BEEF,0,1));

        // Reset while a request is outstanding
        apply(mk("rst_in_drain", 1,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,0,0));
        apply(mk("after_rst",    0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,0,0));

        // Timeout: COLLECT for exactly 255 cycles without a commit
        apply(mk("to_wstart",    0,1,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,0,1));
        idle_cycles(253);
        apply(mk("to_cycle254",  0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,0,1));
        apply(mk("to_cycle255",  0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,1,0));
        apply(mk("to_wr_idle",   0,0,1,0, 8'h10, 32'h8000_1111, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,1,0));
        apply(mk("to_commit",    0,0,0,1, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,1,0));
        apply(mk("to_no_req",    0,0,0,0, 8'h00, 32'h0000_0000, 0,0, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,1,0));
        apply(mk("to_err_clr",   0,0,0,0, 8'h00, 32'h0000_0000, 0,1, 0,0,16'h0000,0,4'b0000,4'b0000,0,32'h0000_0000,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
